// File: rtl/execute_mem_ldret_if.sv
// Load-return bus bundle: request issue, memory response and writeback result.
// Signal names keep their i_/o_ prefixes as seen from the tracker (slave) side.
interface execute_mem_ldret_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_signed;
    logic [5:0]  i_req_dst;
    logic        i_rsp_valid;
    logic        o_rsp_ready;
    logic [31:0] i_rsp_data;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [31:0] o_wb_data;
    logic [5:0]  o_wb_dst;
    logic        o_wb_misalign;

    modport master (
        output i_req_valid, i_req_addr, i_req_size, i_req_signed, i_req_dst,
        output i_rsp_valid, i_rsp_data, i_wb_ready,
        input  o_req_ready, o_rsp_ready, o_wb_valid, o_wb_data, o_wb_dst, o_wb_misalign
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_size, i_req_signed, i_req_dst,
        input  i_rsp_valid, i_rsp_data, i_wb_ready,
        output o_req_ready, o_rsp_ready, o_wb_valid, o_wb_data, o_wb_dst, o_wb_misalign
    );
endinterface

// File: rtl/execute_mem_ldret.sv
// In-order load tracker: remembers attributes of issued loads, then aligns and
// extends each returning memory word into a registered writeback result.
module execute_mem_ldret #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    execute_mem_ldret_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [1:0] addr;
        logic [1:0] size;
        logic       sgn;
        logic [5:0] dst;
    } entry_t;

    entry_t        entry_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic          wb_valid_reg;
    logic [31:0]   wb_data_reg;
    logic [5:0]    wb_dst_reg;
    logic          wb_misalign_reg;

    logic          req_ready;
    logic          rsp_ready;
    logic          push;
    logic          pop;
    entry_t        head;
    logic [7:0]    lane [4];
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   fmt_data_next;
    logic          fmt_mis_next;

    // Full is a hard stop: a pop in the same cycle does not make room.
    assign req_ready = (count_reg != FULL);
    assign rsp_ready = (count_reg != '0) && (!wb_valid_reg || bus.i_wb_ready);
    assign push      = bus.i_req_valid && req_ready;
    assign pop       = bus.i_rsp_valid && rsp_ready;
    assign head      = entry_reg[rd_ptr_reg];

    assign bus.o_req_ready   = req_ready;
    assign bus.o_rsp_ready   = rsp_ready;
    assign bus.o_wb_valid    = wb_valid_reg;
    assign bus.o_wb_data     = wb_data_reg;
    assign bus.o_wb_dst      = wb_dst_reg;
    assign bus.o_wb_misalign = wb_misalign_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = bus.i_rsp_data[8*gi +: 8];
    end

    assign byte_sel = lane[head.addr];
    assign half_sel = head.addr[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    // Misaligned and reserved-size loads pass the raw word through untouched.
    always_comb begin
        fmt_data_next = bus.i_rsp_data;
        fmt_mis_next  = 1'b0;
        case (head.size)
            2'b00: fmt_data_next = {{24{head.sgn & byte_sel[7]}}, byte_sel};
            2'b01: begin
                if (head.addr[0]) fmt_mis_next = 1'b1;
                else              fmt_data_next = {{16{head.sgn & half_sel[15]}}, half_sel};
            end
            2'b10:   fmt_mis_next = (head.addr != 2'b00);
            default: fmt_mis_next = 1'b1;
        endcase
    end

    // Attribute storage carries no reset; an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_reg[wr_ptr_reg] <= '{addr: bus.i_req_addr, size: bus.i_req_size,
                                       sgn:  bus.i_req_signed, dst: bus.i_req_dst};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            wb_valid_reg    <= 1'b0;
            wb_data_reg     <= '0;
            wb_dst_reg      <= '0;
            wb_misalign_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (pop) begin
                wb_valid_reg    <= 1'b1;
                wb_data_reg     <= fmt_data_next;
                wb_dst_reg      <= head.dst;
                wb_misalign_reg <= fmt_mis_next;
            end else if (bus.i_wb_ready) begin
                wb_valid_reg    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_execute_mem_ldret.sv
// Bench for the load tracker: directed vector table, hand-built corner
// sequences, and a randomized run against a queue-based reference model.
module tb_execute_mem_ldret;
    localparam int DEPTH = 4;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    execute_mem_ldret_if bus ();

    execute_mem_ldret #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  addr;
        logic [1:0]  size;
        logic        sgn;
        logic [5:0]  dst;
        logic [31:0] rsp;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [1:0] addr;
        logic [1:0] size;
        logic       sgn;
        logic [5:0] dst;
    } req_t;

    vec_t vecs [13];
    req_t model_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_req_valid  = 1'b0;
        bus.i_req_addr   = 2'b00;
        bus.i_req_size   = 2'b00;
        bus.i_req_signed = 1'b0;
        bus.i_req_dst    = 6'd0;
        bus.i_rsp_valid  = 1'b0;
        bus.i_rsp_data   = 32'd0;
        bus.i_wb_ready   = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_req(input logic [1:0] a, input logic [1:0] s, input logic sg, input logic [5:0] d);
        bus.i_req_valid  = 1'b1;
        bus.i_req_addr   = a;
        bus.i_req_size   = s;
        bus.i_req_signed = sg;
        bus.i_req_dst    = d;
    endtask

    // Reference formatting from the load rules, {misalign, data}.
    function automatic logic [32:0] ref_fmt(input logic [1:0] a, input logic [1:0] s,
                                            input logic sg, input logic [31:0] d);
        int unsigned v;
        case (s)
            2'd0: begin
                v = (d >> (8 * int'(a))) & 32'hFF;
                if (sg && v >= 128) v = v + 32'hFFFF_FF00;
                return {1'b0, v};
            end
            2'd1: begin
                if (a[0]) return {1'b1, d};
                v = (d >> (16 * int'(a[1]))) & 32'hFFFF;
                if (sg && v >= 32768) v = v + 32'hFFFF_0000;
                return {1'b0, v};
            end
            2'd2:    return {(a != 2'd0), d};
            default: return {1'b1, d};
        endcase
    endfunction

    initial begin
        logic        m_valid;
        logic [31:0] m_data;
        logic [5:0]  m_dst;
        logic        m_mis;
        logic [32:0] f;
        logic [31:0] held;
        logic        do_push, do_pop;
        req_t        r;

        vecs[0]  = '{2'd3, 2'd0, 1'b1, 6'd5,  32'h80FF_FF12, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{2'd2, 2'd1, 1'b0, 6'd9,  32'hBEEF_1234, 32'h0000_BEEF, 1'b0};
        vecs[2]  = '{2'd1, 2'd2, 1'b0, 6'd3,  32'h1122_3344, 32'h1122_3344, 1'b1};
        vecs[3]  = '{2'd0, 2'd0, 1'b0, 6'd1,  32'h1122_3384, 32'h0000_0084, 1'b0};
        vecs[4]  = '{2'd0, 2'd0, 1'b1, 6'd2,  32'h1122_3384, 32'hFFFF_FF84, 1'b0};
        vecs[5]  = '{2'd1, 2'd0, 1'b1, 6'd7,  32'h1122_7F44, 32'h0000_007F, 1'b0};
        vecs[6]  = '{2'd0, 2'd1, 1'b1, 6'd10, 32'h1234_F00D, 32'hFFFF_F00D, 1'b0};
        vecs[7]  = '{2'd2, 2'd1, 1'b1, 6'd11, 32'h7FFF_0000, 32'h0000_7FFF, 1'b0};
        vecs[8]  = '{2'd1, 2'd1, 1'b0, 6'd12, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1};
        vecs[9]  = '{2'd0, 2'd2, 1'b1, 6'd13, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{2'd0, 2'd3, 1'b0, 6'd14, 32'h0102_0304, 32'h0102_0304, 1'b1};
        vecs[11] = '{2'd2, 2'd0, 1'b0, 6'd63, 32'hA5B6_C7D8, 32'h0000_00B6, 1'b0};
        vecs[12] = '{2'd3, 2'd1, 1'b1, 6'd20, 32'h8000_8000, 32'h8000_8000, 1'b1};

        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        chk("reset_req_ready", 32'(bus.o_req_ready), 32'd1);
        chk("reset_rsp_ready", 32'(bus.o_rsp_ready), 32'd0);
        chk("reset_wb_valid",  32'(bus.o_wb_valid),  32'd0);
        chk("reset_wb_data",   bus.o_wb_data,        32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed vectors: one push, one response, check the next cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            idle_inputs();
            set_req(vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].dst);
            @(negedge clk);
            idle_inputs();
            bus.i_rsp_valid = 1'b1;
            bus.i_rsp_data  = vecs[i].rsp;
            #1;
            chk($sformatf("vec%0d_rsp_ready", i), 32'(bus.o_rsp_ready), 32'd1);
            @(negedge clk);
            bus.i_rsp_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_wb_valid", i), 32'(bus.o_wb_valid), 32'd1);
            chk($sformatf("vec%0d_wb_data", i),  bus.o_wb_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_wb_dst", i),   32'(bus.o_wb_dst), 32'(vecs[i].dst));
            chk($sformatf("vec%0d_wb_mis", i),   32'(bus.o_wb_misalign), 32'(vecs[i].exp_mis));
            $display("vec %0d: addr=%0d size=%0d sgn=%0d rsp=%h -> data=%h mis=%0d",
                     i, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].rsp,
                     bus.o_wb_data, bus.o_wb_misalign);
        end

        // Response with nothing outstanding is ignored.
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        bus.i_rsp_valid = 1'b1;
        bus.i_rsp_data  = 32'h5555_AAAA;
        #1;
        chk("empty_rsp_ready", 32'(bus.o_rsp_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("empty_rsp_no_wb", 32'(bus.o_wb_valid), 32'd0);
        $display("seq empty-response: wb_valid=%0d", bus.o_wb_valid);

        // Fill to DEPTH, then pop at full (no bypass), then push+pop at count 3.
        apply_reset();
        set_req(2'd0, 2'd2, 1'b0, 6'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("full_req_ready", 32'(bus.o_req_ready), 32'd0);
        bus.i_rsp_valid = 1'b1;
        bus.i_rsp_data  = 32'h0000_0001;
        @(negedge clk);
        #1;
        chk("cnt3_req_ready", 32'(bus.o_req_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("pushpop_req_ready", 32'(bus.o_req_ready), 32'd1);
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("drain_last_rsp_ready", 32'(bus.o_rsp_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("drained_rsp_ready", 32'(bus.o_rsp_ready), 32'd0);
        $display("seq full/push-pop: rsp_ready after drain=%0d", bus.o_rsp_ready);

        // Backpressure: result held three cycles, then the next load replaces it.
        apply_reset();
        set_req(2'd0, 2'd2, 1'b0, 6'd21);
        @(negedge clk);
        set_req(2'd0, 2'd0, 1'b0, 6'd22);
        @(negedge clk);
        idle_inputs();
        bus.i_wb_ready  = 1'b0;
        bus.i_rsp_valid = 1'b1;
        bus.i_rsp_data  = 32'hAAAA_5555;
        @(negedge clk);
        bus.i_rsp_data  = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_rsp_ready", k), 32'(bus.o_rsp_ready), 32'd0);
            chk($sformatf("hold%0d_wb_valid", k),  32'(bus.o_wb_valid), 32'd1);
            chk($sformatf("hold%0d_wb_data", k),   bus.o_wb_data, 32'hAAAA_5555);
            chk($sformatf("hold%0d_wb_dst", k),    32'(bus.o_wb_dst), 32'd21);
            @(negedge clk);
        end
        bus.i_wb_ready = 1'b1;
        #1;
        chk("release_rsp_ready", 32'(bus.o_rsp_ready), 32'd1);
        @(negedge clk);
        bus.i_rsp_valid = 1'b0;
        #1;
        chk("release_wb_valid", 32'(bus.o_wb_valid), 32'd1);
        chk("release_wb_data",  bus.o_wb_data, 32'h0000_0078);
        chk("release_wb_dst",   32'(bus.o_wb_dst), 32'd22);
        $display("seq backpressure: next data=%h dst=%0d", bus.o_wb_data, bus.o_wb_dst);

        // Reset in the middle of work: two pending entries and a held result.
        apply_reset();
        set_req(2'd0, 2'd2, 1'b1, 6'd30);
        repeat (3) @(negedge clk);
        idle_inputs();
        bus.i_wb_ready  = 1'b0;
        bus.i_rsp_valid = 1'b1;
        bus.i_rsp_data  = 32'hFEED_F00D;
        @(negedge clk);
        bus.i_rsp_valid = 1'b0;
        #1;
        chk("prereset_wb_valid", 32'(bus.o_wb_valid), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("midreset_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        chk("midreset_wb_data",  bus.o_wb_data, 32'd0);
        chk("midreset_wb_dst",   32'(bus.o_wb_dst), 32'd0);
        chk("midreset_wb_mis",   32'(bus.o_wb_misalign), 32'd0);
        chk("midreset_req_ready", 32'(bus.o_req_ready), 32'd1);
        chk("midreset_rsp_ready", 32'(bus.o_rsp_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        bus.i_wb_ready  = 1'b1;
        bus.i_rsp_valid = 1'b1;
        #1;
        chk("postreset_rsp_ready", 32'(bus.o_rsp_ready), 32'd0);
        @(negedge clk);
        bus.i_rsp_valid = 1'b0;
        #1;
        chk("postreset_wb_valid",  32'(bus.o_wb_valid), 32'd0);
        chk("postreset_req_ready", 32'(bus.o_req_ready), 32'd1);
        $display("seq mid-reset: wb_valid=%0d req_ready=%0d", bus.o_wb_valid, bus.o_req_ready);

        // Randomized traffic against a queue model.
        apply_reset();
        model_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_dst   = '0;
        m_mis   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.i_req_valid  = ($urandom_range(0, 9) < 6);
            bus.i_req_addr   = 2'($urandom_range(0, 3));
            bus.i_req_size   = 2'($urandom_range(0, 3));
            bus.i_req_signed = 1'($urandom_range(0, 1));
            bus.i_req_dst    = 6'($urandom_range(0, 63));
            bus.i_rsp_valid  = ($urandom_range(0, 9) < 5);
            bus.i_rsp_data   = $urandom;
            bus.i_wb_ready   = ($urandom_range(0, 9) < 7);
            #1;
            do_push = bus.i_req_valid && (model_q.size() != DEPTH);
            do_pop  = bus.i_rsp_valid && (model_q.size() != 0) && (!m_valid || bus.i_wb_ready);
            chk("rnd_req_ready", 32'(bus.o_req_ready), 32'(model_q.size() != DEPTH));
            chk("rnd_rsp_ready", 32'(bus.o_rsp_ready),
                32'((model_q.size() != 0) && (!m_valid || bus.i_wb_ready)));
            chk("rnd_wb_valid", 32'(bus.o_wb_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_wb_data", bus.o_wb_data, m_data);
                chk("rnd_wb_dst",  32'(bus.o_wb_dst), 32'(m_dst));
                chk("rnd_wb_mis",  32'(bus.o_wb_misalign), 32'(m_mis));
            end
            held = bus.i_rsp_data;
            if (do_pop) begin
                r = model_q.pop_front();
                f = ref_fmt(r.addr, r.size, r.sgn, held);
                m_valid = 1'b1;
                m_data  = f[31:0];
                m_mis   = f[32];
                m_dst   = r.dst;
            end else if (bus.i_wb_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) begin
                r.addr = bus.i_req_addr;
                r.size = bus.i_req_size;
                r.sgn  = bus.i_req_signed;
                r.dst  = bus.i_req_dst;
                model_q.push_back(r);
            end
        end
        $display("random phase: %0d checks so far, %0d errors", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
